// File: rtl/spcpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : spcpu_mem_arbiter_if
//  Purpose  : Bundles the two requester ports and the single memory port
//             that spcpu_mem_arbiter connects.
//  Modports : master - the arbiter side. It receives requests and memory
//                      responses, and drives completions and the memory request.
//             slave  - the requesters/memory side. It is the mirror image.
//  Signals  : rq_req_rdwr/rq_addr/rq_acc_sz/rq_we/rq_wdata  per-port requests
//             rq_data_ready/rq_rdata/rq_error             per-port completion
//             mem_req_rdwr/mem_addr/mem_acc_sz/mem_we/mem_wdata  to memory
//             mem_rdata/mem_data_ready                   from memory
//             grant_id/busy                              arbiter status
//  Revision : 1.0 - initial release
// ============================================================================
interface spcpu_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) ();
  logic [1:0]              rq_req_rdwr;
  logic [2*ADDR_WIDTH-1:0] rq_addr;
  logic [1:0]              rq_acc_sz;
  logic [1:0]              rq_we;
  logic [2*DATA_WIDTH-1:0] rq_wdata;
  logic [1:0]              rq_data_ready;
  logic [DATA_WIDTH-1:0]   rq_rdata;
  logic [1:0]              rq_error;
  logic                    mem_req_rdwr;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_acc_sz;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_data_ready;
  logic                    grant_id;
  logic                    busy;

  modport master (
    input  rq_req_rdwr, rq_addr, rq_acc_sz, rq_we, rq_wdata,
    input  mem_rdata, mem_data_ready,
    output rq_data_ready, rq_rdata, rq_error,
    output mem_req_rdwr, mem_addr, mem_acc_sz, mem_we, mem_wdata,
    output grant_id, busy
  );

  modport slave (
    output rq_req_rdwr, rq_addr, rq_acc_sz, rq_we, rq_wdata,
    output mem_rdata, mem_data_ready,
    input  rq_data_ready, rq_rdata, rq_error,
    input  mem_req_rdwr, mem_addr, mem_acc_sz, mem_we, mem_wdata,
    input  grant_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/spcpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spcpu_mem_arbiter
//  Purpose  : Shares one memory port between port 0 (spcpu core) and port 1
//             (DMA/debug loader). Only one transaction is forwarded at a time.
//             Grants are round-robin, and port 0 wins the first tie after
//             reset. A per-transaction timeout aborts a hung memory access.
//  Ports    : clk    - clock shared with the memory and the requesters
//             reset  - synchronous reset, active low
//             bus    - spcpu_mem_arbiter_if.master; carries the requester
//                      ports, the memory port and the grant_id/busy status
//  Revision : 1.0 - initial release
// ============================================================================
module spcpu_mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                clk,
  input  logic                reset,
  spcpu_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The counter starts at 0 in the first BUSY cycle. When it holds
  // TIMEOUT_CYCLES-1, that BUSY cycle is number TIMEOUT_CYCLES, so it is the
  // abort cycle.
  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                r_state,         w_state;
  logic                  r_last_grant,    w_last_grant;
  logic                  r_grant_id,      w_grant_id;
  logic [CNT_WIDTH-1:0]  r_cnt,           w_cnt;
  logic                  r_mem_req,       w_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr,      w_mem_addr;
  logic                  r_mem_acc_sz,    w_mem_acc_sz;
  logic                  r_mem_we,        w_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_wdata,     w_mem_wdata;
  logic [1:0]            r_rq_data_ready, w_rq_data_ready;
  logic [DATA_WIDTH-1:0] r_rq_rdata,      w_rq_rdata;
  logic [1:0]            r_rq_error,      w_rq_error;
  logic                  w_winner;
  logic [1:0]            w_grant_onehot;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_last_grant    <= 1'b1;   // makes port 0 the first tie winner
      r_grant_id      <= 1'b0;
      r_cnt           <= '0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_acc_sz    <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_wdata     <= '0;
      r_rq_data_ready <= 2'b00;
      r_rq_rdata      <= '0;
      r_rq_error      <= 2'b00;
    end else begin
      r_state         <= w_state;
      r_last_grant    <= w_last_grant;
      r_grant_id      <= w_grant_id;
      r_cnt           <= w_cnt;
      r_mem_req       <= w_mem_req;
      r_mem_addr      <= w_mem_addr;
      r_mem_acc_sz    <= w_mem_acc_sz;
      r_mem_we        <= w_mem_we;
      r_mem_wdata     <= w_mem_wdata;
      r_rq_data_ready <= w_rq_data_ready;
      r_rq_rdata      <= w_rq_rdata;
      r_rq_error      <= w_rq_error;
    end
  end

  assign w_grant_onehot = r_grant_id ? 2'b10 : 2'b01;

  always_comb begin
    w_state         = r_state;
    w_last_grant    = r_last_grant;
    w_grant_id      = r_grant_id;
    w_cnt           = r_cnt;
    w_mem_req       = r_mem_req;
    w_mem_addr      = r_mem_addr;
    w_mem_acc_sz    = r_mem_acc_sz;
    w_mem_we        = r_mem_we;
    w_mem_wdata     = r_mem_wdata;
    w_rq_data_ready = r_rq_data_ready;
    w_rq_rdata      = r_rq_rdata;
    w_rq_error      = r_rq_error;
    w_winner        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_rq_data_ready = 2'b00;
        w_rq_error      = 2'b00;
        if (|bus.rq_req_rdwr) begin
          // On contention, grant the port that did not win last time.
          if (bus.rq_req_rdwr == 2'b11) begin
            w_winner = ~r_last_grant;
          end else begin
            w_winner = bus.rq_req_rdwr[1];
          end
          w_mem_addr   = w_winner ? bus.rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : bus.rq_addr[ADDR_WIDTH-1:0];
          w_mem_wdata  = w_winner ? bus.rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : bus.rq_wdata[DATA_WIDTH-1:0];
          w_mem_acc_sz = bus.rq_acc_sz[w_winner];
          w_mem_we     = bus.rq_we[w_winner];
          w_mem_req    = 1'b1;
          w_grant_id   = w_winner;
          w_last_grant = w_winner;
          w_cnt        = '0;
          w_state      = S_BUSY;
        end
      end

      S_BUSY: begin
        w_cnt = r_cnt + 1'b1;
        // If ready and timeout fall in the same cycle, ready is checked
        // first, so the access completes normally.
        if (bus.mem_data_ready) begin
          w_rq_data_ready = w_grant_onehot;
          w_rq_rdata      = bus.mem_rdata;
          w_mem_req       = 1'b0;
          w_state         = S_DONE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_rq_data_ready = w_grant_onehot;
          w_rq_error      = w_grant_onehot;
          w_rq_rdata      = '0;
          w_mem_req       = 1'b0;
          w_state         = S_DONE;
        end
      end

      S_DONE: begin
        // This bubble cycle lets the memory see mem_req_rdwr low before the
        // next request can be issued.
        w_rq_data_ready = 2'b00;
        w_rq_error      = 2'b00;
        w_rq_rdata      = '0;
        w_state         = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.rq_data_ready = r_rq_data_ready;
  assign bus.rq_rdata      = r_rq_rdata;
  assign bus.rq_error      = r_rq_error;
  assign bus.mem_req_rdwr  = r_mem_req;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_acc_sz    = r_mem_acc_sz;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.grant_id      = r_grant_id;
  assign bus.busy          = (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_spcpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spcpu_mem_arbiter
//  Purpose  : Directed self-checking bench for spcpu_mem_arbiter. The bench
//             drives both requester ports and the memory response itself.
//             Inputs change, and outputs are sampled, on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spcpu_mem_arbiter;

  localparam int c_AW = 16;
  localparam int c_DW = 16;
  localparam int c_TO = 4;
  // Access-size encoding as forwarded to the memory (8-bit = 0, 16-bit = 1).
  localparam logic c_SZ8  = 1'b0;
  localparam logic c_SZ16 = 1'b1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  spcpu_mem_arbiter_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus ();

  spcpu_mem_arbiter #(
    .ADDR_WIDTH     (c_AW),
    .DATA_WIDTH     (c_DW),
    .TIMEOUT_CYCLES (c_TO),
    .CNT_WIDTH      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.rq_req_rdwr    = 2'b00;
    bus.rq_addr        = '0;
    bus.rq_acc_sz      = 2'b00;
    bus.rq_we          = 2'b00;
    bus.rq_wdata       = '0;
    bus.mem_rdata      = '0;
    bus.mem_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    tick(3);
    n_checks++;
    if ({bus.mem_req_rdwr, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hold: req/busy=%b expected 00", {bus.mem_req_rdwr, bus.busy});
    end
    reset = 1'b1;
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.rq_error, bus.rq_rdata, bus.mem_req_rdwr, bus.mem_addr,
         bus.mem_acc_sz, bus.mem_we, bus.mem_wdata, bus.grant_id, bus.busy} !== 57'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.rq_data_ready, bus.rq_error, bus.rq_rdata, bus.mem_req_rdwr, bus.mem_addr,
                bus.mem_acc_sz, bus.mem_we, bus.mem_wdata, bus.grant_id, bus.busy});
    end
    // first port-0 read after reset
    bus.rq_req_rdwr   = 2'b01;
    bus.rq_addr[15:0] = 16'h0010;
    bus.rq_acc_sz[0]  = c_SZ16;
    tick(1);
    n_checks++;
    if ({bus.mem_req_rdwr, bus.mem_addr, bus.grant_id, bus.busy, bus.mem_we} !== {1'b1, 16'h0010, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h gnt=%b busy=%b we=%b expected 1 0010 0 1 0",
               bus.mem_req_rdwr, bus.mem_addr, bus.grant_id, bus.busy, bus.mem_we);
    end
    bus.mem_data_ready = 1'b1;
    bus.mem_rdata      = 16'h1234;
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.rq_rdata} !== {2'b01, 16'h1234}) begin
      n_fail++;
      $display("FAIL first_ready: rdy=%b rdata=%h expected 01 1234", bus.rq_data_ready, bus.rq_rdata);
    end
    idle_inputs();
    tick(1);
  endtask

  task automatic test_read();
    bus.rq_req_rdwr   = 2'b01;
    bus.rq_addr[15:0] = 16'h0100;
    bus.rq_acc_sz[0]  = c_SZ16;
    tick(1);
    n_checks++;
    if ({bus.mem_addr, bus.mem_acc_sz} !== {16'h0100, c_SZ16}) begin
      n_fail++;
      $display("FAIL read_addr: addr=%h sz=%b expected 0100 1", bus.mem_addr, bus.mem_acc_sz);
    end
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.mem_req_rdwr} !== 3'b001) begin
      n_fail++;
      $display("FAIL read_wait: rdy=%b req=%b expected 00 1", bus.rq_data_ready, bus.mem_req_rdwr);
    end
    bus.mem_data_ready = 1'b1;
    bus.mem_rdata      = 16'hBEEF;
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.rq_rdata, bus.rq_error, bus.mem_req_rdwr} !== {2'b01, 16'hBEEF, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL read_ready: rdy=%b rdata=%h err=%b req=%b expected 01 beef 00 0",
               bus.rq_data_ready, bus.rq_rdata, bus.rq_error, bus.mem_req_rdwr);
    end
    idle_inputs();
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL read_pulse_end: rdy=%b busy=%b expected 00 0", bus.rq_data_ready, bus.busy);
    end
  endtask

  task automatic test_contention();
    logic       g;
    logic [1:0] exp_rdy;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    bus.rq_req_rdwr = 2'b11;
    bus.rq_addr     = {16'h0300, 16'h0200};
    for (int i = 0; i < 4; i++) begin
      g       = (i % 2 == 1);
      exp_rdy = g ? 2'b10 : 2'b01;
      tick(1);
      n_checks++;
      if ({bus.grant_id, bus.mem_addr} !== {g, (g ? 16'h0300 : 16'h0200)}) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: gnt=%b addr=%h expected %b %h", i, bus.grant_id, bus.mem_addr,
                 g, (g ? 16'h0300 : 16'h0200));
      end
      bus.mem_data_ready = 1'b1;
      bus.mem_rdata      = 16'hA000 + 16'(i);
      tick(1);
      n_checks++;
      if ({bus.rq_data_ready, bus.rq_rdata} !== {exp_rdy, 16'hA000 + 16'(i)}) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: rdy=%b rdata=%h expected %b %h", i, bus.rq_data_ready,
                 bus.rq_rdata, exp_rdy, 16'hA000 + 16'(i));
      end
      bus.mem_data_ready = 1'b0;
      tick(1);
      n_checks++;
      if ({bus.rq_data_ready, bus.mem_req_rdwr} !== 3'b000) begin
        n_fail++;
        $display("FAIL rr_bubble[%0d]: rdy=%b req=%b expected 00 0", i, bus.rq_data_ready, bus.mem_req_rdwr);
      end
    end
    idle_inputs();
    tick(1);
  endtask

  task automatic test_write();
    bus.rq_req_rdwr = 2'b10;
    bus.rq_addr     = {16'h0003, 16'h7777};
    bus.rq_acc_sz   = {c_SZ8, c_SZ16};
    bus.rq_we       = 2'b10;
    bus.rq_wdata    = {16'h005A, 16'h1111};
    tick(1);
    n_checks++;
    if ({bus.mem_we, bus.mem_acc_sz, bus.mem_wdata[7:0], bus.mem_addr, bus.grant_id} !==
        {1'b1, c_SZ8, 8'h5A, 16'h0003, 1'b1}) begin
      n_fail++;
      $display("FAIL write_fields: we=%b sz=%b wd=%h addr=%h gnt=%b expected 1 0 5a 0003 1",
               bus.mem_we, bus.mem_acc_sz, bus.mem_wdata[7:0], bus.mem_addr, bus.grant_id);
    end
    // request-side changes while BUSY must not reach the memory port
    bus.rq_addr  = {16'hFFFF, 16'hFFFF};
    bus.rq_wdata = {16'hFFFF, 16'hFFFF};
    bus.rq_we    = 2'b00;
    tick(1);
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== {16'h0003, 16'h005A, 1'b1}) begin
      n_fail++;
      $display("FAIL write_frozen: addr=%h wd=%h we=%b expected 0003 005a 1",
               bus.mem_addr, bus.mem_wdata, bus.mem_we);
    end
    bus.mem_data_ready = 1'b1;
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.rq_error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL write_ready: rdy=%b err=%b expected 10 00", bus.rq_data_ready, bus.rq_error);
    end
    idle_inputs();
    tick(1);
  endtask

  task automatic test_timeout();
    bus.rq_req_rdwr   = 2'b01;
    bus.rq_addr[15:0] = 16'h0400;
    bus.mem_rdata     = 16'hDEAD;
    tick(1);
    for (int i = 2; i <= c_TO; i++) begin
      tick(1);
      n_checks++;
      if ({bus.rq_data_ready, bus.rq_error, bus.mem_req_rdwr} !== 5'b00001) begin
        n_fail++;
        $display("FAIL to_wait[%0d]: rdy=%b err=%b req=%b expected 00 00 1", i,
                 bus.rq_data_ready, bus.rq_error, bus.mem_req_rdwr);
      end
    end
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.rq_error, bus.rq_rdata, bus.mem_req_rdwr} !== {2'b01, 2'b01, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL to_abort: rdy=%b err=%b rdata=%h req=%b expected 01 01 0000 0",
               bus.rq_data_ready, bus.rq_error, bus.rq_rdata, bus.mem_req_rdwr);
    end
    idle_inputs();
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.rq_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_clear: rdy=%b err=%b expected 00 00", bus.rq_data_ready, bus.rq_error);
    end
    // a ready that lands in the timeout cycle completes normally
    bus.rq_req_rdwr   = 2'b01;
    bus.rq_addr[15:0] = 16'h0404;
    tick(1);
    tick(c_TO - 1);
    bus.mem_data_ready = 1'b1;
    bus.mem_rdata      = 16'hCAFE;
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.rq_error, bus.rq_rdata} !== {2'b01, 2'b00, 16'hCAFE}) begin
      n_fail++;
      $display("FAIL to_race: rdy=%b err=%b rdata=%h expected 01 00 cafe",
               bus.rq_data_ready, bus.rq_error, bus.rq_rdata);
    end
    idle_inputs();
    tick(1);
    // a stray memory ready while idle is not forwarded
    bus.mem_data_ready = 1'b1;
    tick(1);
    n_checks++;
    if ({bus.rq_data_ready, bus.busy, bus.mem_req_rdwr} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_ready: rdy=%b busy=%b req=%b expected 00 0 0",
               bus.rq_data_ready, bus.busy, bus.mem_req_rdwr);
    end
    idle_inputs();
    tick(1);
  endtask

  task automatic test_reset_mid();
    // port 0 becomes last_grant, so only a reset can make it win the next tie
    bus.rq_req_rdwr   = 2'b01;
    bus.rq_addr[15:0] = 16'h0500;
    tick(1);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b expected 1", bus.busy);
    end
    reset = 1'b0;
    tick(1);
    n_checks++;
    if ({bus.mem_req_rdwr, bus.busy, bus.rq_data_ready, bus.rq_error} !== 6'b000000) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b busy=%b rdy=%b err=%b expected 0 0 00 00",
               bus.mem_req_rdwr, bus.busy, bus.rq_data_ready, bus.rq_error);
    end
    reset           = 1'b1;
    bus.rq_req_rdwr = 2'b11;
    bus.rq_addr     = {16'h0600, 16'h0500};
    tick(1);
    n_checks++;
    if ({bus.grant_id, bus.mem_addr, bus.mem_req_rdwr} !== {1'b0, 16'h0500, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_tie: gnt=%b addr=%h req=%b expected 0 0500 1",
               bus.grant_id, bus.mem_addr, bus.mem_req_rdwr);
    end
    bus.mem_data_ready = 1'b1;
    tick(1);
    n_checks++;
    if (bus.rq_data_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_ready: rdy=%b expected 01", bus.rq_data_ready);
    end
    idle_inputs();
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_contention();
    test_write();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
